// File: rtl/rvm_lsu.sv
// rvm_lsu: single-outstanding load/store unit driving the word-addressed memory bus.
// Optional macro RVM_LSU_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES stall cycles.
module rvm_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic        mem_c_en,
    output logic        mem_w_en,
    output logic [3:0]  mem_b_en,
    input  logic        mem_error,
    input  logic        mem_stall
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rvm_lsu: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;

    logic        req_ready_d, rsp_valid_d, rsp_error_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;
    logic        mem_c_en_d, mem_w_en_d;
    logic [3:0]  mem_b_en_d;

    logic        req_bad;
    logic [3:0]  lanes;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_ext;

`ifdef RVM_LSU_TIMEOUT_EN
    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);
    logic [15:0] tmo_cnt, tmo_cnt_d;
    logic [16:0] tmo_inc;
    assign tmo_inc = {1'b0, tmo_cnt} + 17'd1;
`endif

    // Request decode: alignment, lane mask and replicated store data
    always_comb begin
        req_bad   = 1'b0;
        lanes     = 4'b1111;
        wdata_rep = req_wdata;
        unique case (req_size)
            2'b00: begin
                lanes     = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_bad   = req_addr[0];
                lanes     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        unique case (size_q)
            2'b00:   load_ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d     = state;
        off_d       = off_q;
        size_d      = size_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_c_en_d  = 1'b0;
        mem_w_en_d  = 1'b0;
        mem_b_en_d  = '0;
`ifdef RVM_LSU_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                    we_d        = req_we;
                    sgn_d       = req_signed;
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_c_en_d  = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = wdata_rep;
                        mem_w_en_d  = req_we;
                        mem_b_en_d  = lanes;
`ifdef RVM_LSU_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                mem_c_en_d  = 1'b1;
                mem_addr_d  = mem_addr;
                mem_wdata_d = mem_wdata;
                mem_w_en_d  = mem_w_en;
                mem_b_en_d  = mem_b_en;
                if (!mem_stall) begin
                    state_d     = RESP;
                    mem_c_en_d  = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_w_en_d  = 1'b0;
                    mem_b_en_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = mem_error;
                    rsp_rdata_d = (we_q || mem_error) ? 32'h0 : load_ext;
                end
`ifdef RVM_LSU_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_inc[15:0];
                    // Stall-free completion is handled above, so it wins
                    if (tmo_inc >= TMO_LIMIT) begin
                        state_d     = RESP;
                        mem_c_en_d  = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        mem_w_en_d  = 1'b0;
                        mem_b_en_d  = '0;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
`endif
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            off_q     <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_c_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            mem_b_en  <= '0;
`ifdef RVM_LSU_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            off_q     <= off_d;
            size_q    <= size_d;
            we_q      <= we_d;
            sgn_q     <= sgn_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_error <= rsp_error_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_c_en  <= mem_c_en_d;
            mem_w_en  <= mem_w_en_d;
            mem_b_en  <= mem_b_en_d;
`ifdef RVM_LSU_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rvm_lsu.sv
// tb_rvm_lsu: directed scenario tests for rvm_lsu.
// Build with RVM_LSU_TIMEOUT_EN to include the stall-timeout scenario.
module tb_rvm_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    int tests = 0;
    int fails = 0;

    rvm_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_c_en(mem_c_en), .mem_w_en(mem_w_en), .mem_b_en(mem_b_en),
        .mem_error(mem_error), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; returns 1 cycle after the accept edge
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [1:0] sz, input logic sg);
        req_valid  = 1'b1;
        req_addr   = a;
        req_wdata  = d;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        step();
        req_valid  = 1'b0;
    endtask

    // Cycles since accept until rsp_valid seen; -1 if the bound expires
    task automatic wait_rsp(input int start, output int cyc);
        cyc = start;
        while (!rsp_valid && cyc < 40) begin
            step();
            cyc++;
        end
        if (!rsp_valid) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if ({req_ready, rsp_valid, rsp_error, mem_c_en, mem_w_en, mem_b_en} !== 9'b1_0000_0000) begin
            fails++;
            $display("FAIL reset_ctrl got=%b exp=100000000",
                     {req_ready, rsp_valid, rsp_error, mem_c_en, mem_w_en, mem_b_en});
        end
        tests++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            fails++;
            $display("FAIL reset_data got=%h exp=0", {rsp_rdata, mem_addr, mem_wdata});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_word();
        int cyc;
        mem_rdata = 32'hDEADBEEF;
        issue(32'h100, 32'h0, 1'b0, 2'b10, 1'b0);
        tests++;
        if ({mem_c_en, mem_w_en, mem_b_en, req_ready} !== 7'b1_0_1111_0 || mem_addr !== 32'h100) begin
            fails++;
            $display("FAIL lw_bus got cen/wen/ben/rdy=%b addr=%h exp=1011110 addr=00000100",
                     {mem_c_en, mem_w_en, mem_b_en, req_ready}, mem_addr);
        end
        wait_rsp(1, cyc);
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL lw_latency got=%0d exp=2", cyc);
        end
        tests++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_error !== 1'b0) begin
            fails++;
            $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rsp_rdata, rsp_error);
        end
        step();
        tests++;
        if ({rsp_valid, req_ready, mem_c_en} !== 3'b010) begin
            fails++;
            $display("FAIL lw_after got=%b exp=010", {rsp_valid, req_ready, mem_c_en});
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] addrs [4] = '{32'h203, 32'h203, 32'h202, 32'h201};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
        logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  lanes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0010};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00000034};
        int cyc;
        mem_rdata = 32'h80123456;
        for (int i = 0; i < 4; i++) begin
            issue(addrs[i], 32'h0, 1'b0, sizes[i], sgns[i]);
            tests++;
            if (mem_addr !== 32'h200 || mem_b_en !== lanes[i]) begin
                fails++;
                $display("FAIL ld_ext%0d_bus got addr=%h ben=%b exp addr=00000200 ben=%b",
                         i, mem_addr, mem_b_en, lanes[i]);
            end
            wait_rsp(1, cyc);
            tests++;
            if (cyc !== 2 || rsp_rdata !== exps[i] || rsp_error !== 1'b0) begin
                fails++;
                $display("FAIL ld_ext%0d got lat=%0d data=%h err=%b exp lat=2 data=%h err=0",
                         i, cyc, rsp_rdata, rsp_error, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_store_stall();
        int cyc;
        mem_rdata = 32'h80123456;
        mem_stall = 1'b1;
        issue(32'h2, 32'h0000ABCD, 1'b1, 2'b01, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) mem_stall = 1'b0;
            tests++;
            if ({mem_c_en, mem_w_en, mem_b_en} !== 6'b11_1100 ||
                mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h0 || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL sh_stall_c%0d got cen/wen/ben=%b wdata=%h addr=%h rv=%b exp 111100 abcdabcd 0 0",
                         i, {mem_c_en, mem_w_en, mem_b_en}, mem_wdata, mem_addr, rsp_valid);
            end
            if (i < 4) step();
        end
        wait_rsp(4, cyc);
        tests++;
        if (cyc !== 5 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || mem_c_en !== 1'b0) begin
            fails++;
            $display("FAIL sh_stall_rsp got lat=%0d data=%h err=%b cen=%b exp 5 0 0 0",
                     cyc, rsp_rdata, rsp_error, mem_c_en);
        end
        step();
        issue(32'h1, 32'h123456A5, 1'b1, 2'b00, 1'b0);
        tests++;
        if (mem_wdata !== 32'hA5A5A5A5 || mem_b_en !== 4'b0010 || mem_w_en !== 1'b1) begin
            fails++;
            $display("FAIL sb_bus got wdata=%h ben=%b wen=%b exp a5a5a5a5 0010 1",
                     mem_wdata, mem_b_en, mem_w_en);
        end
        wait_rsp(1, cyc);
        step();
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h102, 32'h100, 32'h101};
        logic [1:0]  sizes [3] = '{2'b10, 2'b11, 2'b01};
        int cyc;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            issue(addrs[i], 32'h0, 1'b0, sizes[i], 1'b1);
            tests++;
            if (mem_c_en !== 1'b0 || mem_b_en !== 4'b0) begin
                fails++;
                $display("FAIL misal%0d_bus got cen=%b ben=%b exp 0 0000", i, mem_c_en, mem_b_en);
            end
            wait_rsp(1, cyc);
            tests++;
            if (cyc !== 1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
                fails++;
                $display("FAIL misal%0d_rsp got lat=%0d err=%b data=%h exp 1 1 0",
                         i, cyc, rsp_error, rsp_rdata);
            end
            step();
        end
    endtask

    task automatic test_bus_error();
        int cyc;
        mem_rdata = 32'h11223344;
        mem_stall = 1'b1;
        mem_error = 1'b1;
        issue(32'h40, 32'h0, 1'b0, 2'b10, 1'b0);
        step();
        mem_stall = 1'b0;
        wait_rsp(2, cyc);
        tests++;
        if (cyc !== 3 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL buserr got lat=%0d err=%b data=%h exp 3 1 0", cyc, rsp_error, rsp_rdata);
        end
        step();
        mem_stall = 1'b1;
        mem_error = 1'b1;
        issue(32'h40, 32'h0, 1'b0, 2'b10, 1'b0);
        step();
        mem_stall = 1'b0;
        mem_error = 1'b0;
        wait_rsp(2, cyc);
        tests++;
        if (cyc !== 3 || rsp_error !== 1'b0 || rsp_rdata !== 32'h11223344) begin
            fails++;
            $display("FAIL stall_err_ignored got lat=%0d err=%b data=%h exp 3 0 11223344",
                     cyc, rsp_error, rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        mem_stall = 1'b1;
        issue(32'h80, 32'h0, 1'b0, 2'b10, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if ({mem_c_en, req_ready, rsp_valid} !== 3'b010) begin
            fails++;
            $display("FAIL rst_mid got cen/rdy/rv=%b exp 010", {mem_c_en, req_ready, rsp_valid});
        end
        mem_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_mid_norsp got=%0d pulses exp=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        mem_rdata  = 32'h000000C3;
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (rsp_valid) pulses++;
        end
        req_valid = 1'b0;
        tests++;
        if (pulses !== 3) begin
            fails++;
            $display("FAIL b2b_pulses got=%0d exp=3", pulses);
        end
        step();
        step();
    endtask

`ifdef RVM_LSU_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        mem_stall = 1'b1;
        issue(32'h20, 32'h0, 1'b0, 2'b10, 1'b0);
        wait_rsp(1, cyc);
        tests++;
        if (cyc !== 5 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 || mem_c_en !== 1'b0) begin
            fails++;
            $display("FAIL timeout got lat=%0d err=%b data=%h cen=%b exp 5 1 0 0",
                     cyc, rsp_error, rsp_rdata, mem_c_en);
        end
        mem_stall = 1'b0;
        step();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        mem_rdata  = '0;
        mem_error  = 1'b0;
        mem_stall  = 1'b0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_stall();
        test_misaligned();
        test_bus_error();
        test_reset_mid();
        test_back_to_back();
`ifdef RVM_LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
